ksa_pipe_adder: RTL and testbench

KSA_PIPE_ADDER -- requirements
Module: ksa_pipe_adder

---
 rtl/ksa_pkg.sv | 27 ++
 rtl/ksa_prefix_stage.sv | 71 +++++++
 rtl/ksa_pipe_adder.sv | 115 +++++++++++
 tb/tb_ksa_pipe_adder.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ksa_pkg.sv
// Shared helpers for the pipelined Kogge-Stone adder: log2, operand-width
// legality and the prefix-level count derived from the operand width.
package ksa_pkg;

  localparam int KSA_MIN_WIDTH = 4;
  localparam int KSA_MAX_WIDTH = 64;

  function automatic int ksa_log2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic bit ksa_width_ok(input int width);
    return (width >= KSA_MIN_WIDTH) && (width <= KSA_MAX_WIDTH) &&
           ((width & (width - 1)) == 0);
  endfunction

  // One registered prefix level per doubling of the span.
  function automatic int ksa_stage_count(input int width);
    return ksa_log2(width);
  endfunction

endpackage

// File: rtl/ksa_prefix_stage.sv
// One registered Kogge-Stone prefix level: combines bit i with bit i-DIST,
// forwards the raw propagate vector and carry-in, and owns its pipeline slot.
module ksa_prefix_stage
  import ksa_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIST  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  output logic             o_adv,
  input  logic             i_next_adv,
  input  logic [WIDTH-1:0] i_p,
  input  logic [WIDTH-1:0] i_gp,
  input  logic [WIDTH-1:0] i_gg,
  input  logic             i_cin,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_p,
  output logic [WIDTH-1:0] o_gp,
  output logic [WIDTH-1:0] o_gg,
  output logic             o_cin
);

  logic [WIDTH-1:0] w_gp;
  logic [WIDTH-1:0] w_gg;
  logic             w_adv;

  logic             r_valid;
  logic [WIDTH-1:0] r_p;
  logic [WIDTH-1:0] r_gp;
  logic [WIDTH-1:0] r_gg;
  logic             r_cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (i >= DIST) begin : g_comb
      assign w_gg[i] = i_gg[i] | (i_gp[i] & i_gg[i-DIST]);
      assign w_gp[i] = i_gp[i] & i_gp[i-DIST];
    end else begin : g_pass
      assign w_gg[i] = i_gg[i];
      assign w_gp[i] = i_gp[i];
    end
  end

  // A slot may take new data when it is empty or its occupant moves on.
  assign w_adv = ~r_valid | i_next_adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_p     <= '0;
      r_gp    <= '0;
      r_gg    <= '0;
      r_cin   <= 1'b0;
    end else if (w_adv) begin
      r_valid <= i_valid;
      r_p     <= i_p;
      r_gp    <= w_gp;
      r_gg    <= w_gg;
      r_cin   <= i_cin;
    end
  end

  assign o_adv   = w_adv;
  assign o_valid = r_valid;
  assign o_p     = r_p;
  assign o_gp    = r_gp;
  assign o_gg    = r_gg;
  assign o_cin   = r_cin;

endmodule

// File: rtl/ksa_pipe_adder.sv
// Pipelined Kogge-Stone adder with valid/ready flow control on both sides.
// Optional subtract mode (extra 'sub' port) is built when KSA_SUB_EN is defined.
module ksa_pipe_adder
  import ksa_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Ci,
`ifdef KSA_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Co,
  output logic             Ov
);

  // Handshake: a beat moves across a boundary on a cycle where the sender's
  // valid and the receiver's ready (its advance condition) are both high;
  // ready is a combinational chain back from out_ready, so a full pipe can
  // accept and deliver in the same cycle.

  localparam int N = ksa_stage_count(WIDTH);

  if (!ksa_width_ok(WIDTH)) begin : g_bad_width
    $error("ksa_pipe_adder: WIDTH must be a power of two from 4 to 64");
  end

  logic [WIDTH-1:0] w_bx;
  logic             w_cin;

`ifdef KSA_SUB_EN
  assign w_bx  = B ^ {WIDTH{sub}};
  assign w_cin = Ci ^ sub;
`else
  assign w_bx  = B;
  assign w_cin = Ci;
`endif

  logic [N+1:0]     w_adv;
  logic [N:0]       w_valid;
  logic [N:0]       w_cin_s;
  logic [WIDTH-1:0] w_p  [0:N];
  logic [WIDTH-1:0] w_gp [0:N];
  logic [WIDTH-1:0] w_gg [0:N];

  logic             r_valid0;
  logic [WIDTH-1:0] r_p0;
  logic [WIDTH-1:0] r_g0;
  logic             r_cin0;

  assign w_adv[0]   = ~r_valid0 | w_adv[1];
  assign w_adv[N+1] = out_ready;
  assign in_ready   = w_adv[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid0 <= 1'b0;
      r_p0     <= '0;
      r_g0     <= '0;
      r_cin0   <= 1'b0;
    end else if (w_adv[0]) begin
      r_valid0 <= in_valid;
      r_p0     <= A ^ w_bx;
      r_g0     <= A & w_bx;
      r_cin0   <= w_cin;
    end
  end

  // Stage 0 seeds the prefix tree: group P/G start as the bitwise P/G.
  assign w_valid[0] = r_valid0;
  assign w_cin_s[0] = r_cin0;
  assign w_p[0]     = r_p0;
  assign w_gp[0]    = r_p0;
  assign w_gg[0]    = r_g0;

  for (genvar k = 1; k <= N; k++) begin : g_level
    ksa_prefix_stage #(
      .WIDTH (WIDTH),
      .DIST  (1 << (k - 1))
    ) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_valid    (w_valid[k-1]),
      .o_adv      (w_adv[k]),
      .i_next_adv (w_adv[k+1]),
      .i_p        (w_p[k-1]),
      .i_gp       (w_gp[k-1]),
      .i_gg       (w_gg[k-1]),
      .i_cin      (w_cin_s[k-1]),
      .o_valid    (w_valid[k]),
      .o_p        (w_p[k]),
      .o_gp       (w_gp[k]),
      .o_gg       (w_gg[k]),
      .o_cin      (w_cin_s[k])
    );
  end

  // Cf[i] is the carry out of bit i once the carry-in is folded in.
  logic [WIDTH-1:0] w_cf;

  assign w_cf      = w_gg[N] | (w_gp[N] & {WIDTH{w_cin_s[N]}});
  assign S         = w_p[N] ^ {w_cf[WIDTH-2:0], w_cin_s[N]};
  assign Co        = w_cf[WIDTH-1];
  assign Ov        = w_cf[WIDTH-1] ^ w_cf[WIDTH-2];
  assign out_valid = w_valid[N];

endmodule

// File: tb/tb_ksa_pipe_adder.sv
// Directed and scoreboarded checks of ksa_pipe_adder at WIDTH=16 and WIDTH=64.
module tb_ksa_pipe_adder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        in_valid16, in_ready16, ci16, sub16;
  logic        out_valid16, out_ready16, co16, ov16;
  logic [15:0] a16, b16, s16;

  logic        in_valid64, in_ready64, ci64, sub64;
  logic        out_valid64, out_ready64, co64, ov64;
  logic [63:0] a64, b64, s64;

  ksa_pipe_adder #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .A(a16), .B(b16), .Ci(ci16),
`ifdef KSA_SUB_EN
    .sub(sub16),
`endif
    .out_valid(out_valid16), .out_ready(out_ready16), .S(s16), .Co(co16), .Ov(ov16)
  );

  ksa_pipe_adder #(.WIDTH(64)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid64), .in_ready(in_ready64),
    .A(a64), .B(b64), .Ci(ci64),
`ifdef KSA_SUB_EN
    .sub(sub64),
`endif
    .out_valid(out_valid64), .out_ready(out_ready64), .S(s64), .Co(co64), .Ov(ov64)
  );

  int total = 0;
  int bad   = 0;
  logic [17:0] exp_q[$];

  // Reference result packed as {Ov, Co, S}.
  function automatic logic [17:0] ref16(input logic [15:0] a, input logic [15:0] b,
                                        input logic ci, input logic sb);
    logic [15:0] bx;
    logic [16:0] sum;
    logic        ov;
    bx  = sb ? ~b : b;
    sum = {1'b0, a} + {1'b0, bx} + {16'd0, ci ^ sb};
    ov  = (a[15] == bx[15]) && (sum[15] != a[15]);
    return {ov, sum[16], sum[15:0]};
  endfunction

  task automatic new_ops16();
    a16  = 16'($urandom_range(0, 65535));
    b16  = 16'($urandom_range(0, 65535));
    ci16 = 1'($urandom_range(0, 1));
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid16 = 0; a16 = '0; b16 = '0; ci16 = 0; sub16 = 0; out_ready16 = 1;
    in_valid64 = 0; a64 = '0; b64 = '0; ci64 = 0; sub64 = 0; out_ready64 = 1;
    #3;
    total++; if (out_valid16 !== 1'b0) begin bad++; $display("FAIL reset_out_valid16: got %b want 0", out_valid16); end
    total++; if ({ov16, co16, s16} !== 18'd0) begin bad++; $display("FAIL reset_result16: got %h want 0", {ov16, co16, s16}); end
    total++; if (in_ready16 !== 1'b1) begin bad++; $display("FAIL reset_in_ready16: got %b want 1", in_ready16); end
    total++; if ({out_valid64, ov64, co64, s64} !== 67'd0) begin bad++; $display("FAIL reset_out64: got %h want 0", {out_valid64, ov64, co64, s64}); end
    total++; if (in_ready64 !== 1'b1) begin bad++; $display("FAIL reset_in_ready64: got %b want 1", in_ready64); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed(input string name, input logic [15:0] a, input logic [15:0] b,
                               input logic ci, input logic sb, input logic [15:0] es,
                               input logic eco, input logic eov);
    int lat;
    a16 = a; b16 = b; ci16 = ci; sub16 = sb; in_valid16 = 1; out_ready16 = 1;
    @(negedge clk);
    total++; if (in_ready16 !== 1'b1) begin bad++; $display("FAIL %s_in_ready: got %b want 1", name, in_ready16); end
    @(posedge clk); lat = 1; #1;
    in_valid16 = 0;
    while (!out_valid16 && lat < 20) begin @(posedge clk); lat++; #1; end
    total++; if (lat != 5) begin bad++; $display("FAIL %s_latency: got %0d want 5", name, lat); end
    total++; if ({ov16, co16, s16} !== {eov, eco, es}) begin
      bad++; $display("FAIL %s_result: got S=%h Co=%b Ov=%b want S=%h Co=%b Ov=%b", name, s16, co16, ov16, es, eco, eov);
    end
    @(posedge clk); #1;
    total++; if (out_valid16 !== 1'b0) begin bad++; $display("FAIL %s_single_beat: got out_valid=%b want 0", name, out_valid16); end
    sub16 = 0;
  endtask

  task automatic test_back_to_back();
    int sent, got, cyc, first, last, refused;
    logic [17:0] e;
    sent = 0; got = 0; cyc = 0; first = -1; last = -1; refused = 0;
    out_ready16 = 1; sub16 = 0;
    while (got < 100 && cyc < 200) begin
      if (sent < 100) begin in_valid16 = 1; new_ops16(); end
      else in_valid16 = 0;
      @(negedge clk);
      if (in_valid16 && !in_ready16) refused++;
      if (in_valid16 && in_ready16) begin exp_q.push_back(ref16(a16, b16, ci16, 1'b0)); sent++; end
      if (out_valid16) begin
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL b2b_extra: got S=%h want no beat", s16); end
        else begin
          e = exp_q.pop_front();
          if ({ov16, co16, s16} !== e) begin bad++; $display("FAIL b2b_data: got %h want %h", {ov16, co16, s16}, e); end
        end
        got++; if (first < 0) first = cyc; last = cyc;
      end
      @(posedge clk); #1; cyc++;
    end
    in_valid16 = 0;
    total++; if (got != 100) begin bad++; $display("FAIL b2b_count: got %0d want 100", got); end
    total++; if (last - first != 99) begin bad++; $display("FAIL b2b_rate: got span %0d want 99", last - first); end
    total++; if (refused != 0) begin bad++; $display("FAIL b2b_in_ready: got %0d refusals want 0", refused); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_drain: got %0d left want 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_stall();
    int acc, got;
    logic took;
    logic [17:0] e;
    acc = 0; got = 0; sub16 = 0;
    out_ready16 = 0; in_valid16 = 1; new_ops16();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      took = in_valid16 && in_ready16;
      if (took) begin exp_q.push_back(ref16(a16, b16, ci16, 1'b0)); acc++; end
      @(posedge clk); #1;
      if (took) new_ops16();
    end
    @(negedge clk);
    total++; if (acc != 5) begin bad++; $display("FAIL stall_accepts: got %0d want 5", acc); end
    total++; if (in_ready16 !== 1'b0) begin bad++; $display("FAIL stall_in_ready: got %b want 0", in_ready16); end
    @(posedge clk); #1;
    in_valid16 = 0; out_ready16 = 1;
    #1;
    total++; if (in_ready16 !== 1'b1) begin bad++; $display("FAIL release_in_ready: got %b want 1", in_ready16); end
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (out_valid16) begin
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL stall_extra: got S=%h want no beat", s16); end
        else begin
          e = exp_q.pop_front();
          if ({ov16, co16, s16} !== e) begin bad++; $display("FAIL stall_data: got %h want %h", {ov16, co16, s16}, e); end
        end
        got++;
      end
      @(posedge clk); #1;
    end
    total++; if (got != 5) begin bad++; $display("FAIL stall_results: got %0d want 5", got); end
    exp_q.delete();
  endtask

  task automatic test_random_stall();
    int sent, got, cyc;
    logic took;
    logic [17:0] e;
    sent = 0; got = 0; cyc = 0; in_valid16 = 0; sub16 = 0;
    while (got < 40 && cyc < 600) begin
      if (!in_valid16 && sent < 40 && $urandom_range(0, 3) != 0) begin in_valid16 = 1; new_ops16(); end
      out_ready16 = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      took = in_valid16 && in_ready16;
      if (took) begin exp_q.push_back(ref16(a16, b16, ci16, 1'b0)); sent++; end
      if (out_valid16 && out_ready16) begin
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL rnd_extra: got S=%h want no beat", s16); end
        else begin
          e = exp_q.pop_front();
          if ({ov16, co16, s16} !== e) begin bad++; $display("FAIL rnd_data: got %h want %h", {ov16, co16, s16}, e); end
        end
        got++;
      end
      @(posedge clk); #1; cyc++;
      if (took) in_valid16 = 0;
    end
    in_valid16 = 0; out_ready16 = 1;
    total++; if (got != 40) begin bad++; $display("FAIL rnd_count: got %0d want 40", got); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rnd_drain: got %0d left want 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_reset_flush();
    int seen;
    out_ready16 = 0; sub16 = 0;
    for (int c = 0; c < 3; c++) begin
      in_valid16 = 1; new_ops16();
      @(posedge clk); #1;
    end
    in_valid16 = 0;
    repeat (6) begin @(posedge clk); #1; end
    total++; if (out_valid16 !== 1'b1) begin bad++; $display("FAIL flush_pre_valid: got %b want 1", out_valid16); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (out_valid16 !== 1'b0) begin bad++; $display("FAIL flush_async_valid: got %b want 0", out_valid16); end
    total++; if ({in_ready16, ov16, co16, s16} !== {1'b1, 18'd0}) begin
      bad++; $display("FAIL flush_async_out: got rdy=%b %h want rdy=1 0", in_ready16, {ov16, co16, s16});
    end
    @(negedge clk);
    rst_n = 1'b1; out_ready16 = 1;
    seen = 0;
    repeat (10) begin @(posedge clk); #1; if (out_valid16) seen++; end
    total++; if (seen != 0) begin bad++; $display("FAIL flush_stale: got %0d beats want 0", seen); end
  endtask

  task automatic test_w64();
    int lat;
    a64 = '1; b64 = 64'd1; ci64 = 0; sub64 = 0; in_valid64 = 1; out_ready64 = 1;
    @(posedge clk); lat = 1; #1;
    in_valid64 = 0;
    while (!out_valid64 && lat < 30) begin @(posedge clk); lat++; #1; end
    total++; if (lat != 7) begin bad++; $display("FAIL w64_latency: got %0d want 7", lat); end
    total++; if ({ov64, co64, s64} !== {1'b0, 1'b1, 64'd0}) begin
      bad++; $display("FAIL w64_result: got S=%h Co=%b Ov=%b want S=0 Co=1 Ov=0", s64, co64, ov64);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed("carry_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    test_directed("pos_ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    test_directed("cin_add",    16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
    test_directed("neg_ovf",    16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
`ifdef KSA_SUB_EN
    test_directed("sub_neg",    16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    test_directed("sub_pos",    16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);
`endif
    test_back_to_back();
    test_stall();
    test_random_stall();
    test_reset_flush();
    test_w64();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
